// File: rtl/ntt_coef_loader_if.sv
// Coefficient stream, bank write ports and NTT start/done handshake of the loader.
// The loader connects through the slave modport; upstream and NTT control use master.
interface ntt_coef_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7
);
    logic              load_req;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              ram0_en;
    logic              ram0_we;
    logic [ADDR_W-1:0] ram0_addr;
    logic [DATA_W-1:0] ram0_din;
    logic              ram1_en;
    logic              ram1_we;
    logic [ADDR_W-1:0] ram1_addr;
    logic [DATA_W-1:0] ram1_din;
    logic              ntt_start;
    logic              ntt_done;
    logic              busy;
    logic              done;
    logic              range_err;

    modport master (
        output load_req, s_valid, s_data, ntt_done,
        input  s_ready, ram0_en, ram0_we, ram0_addr, ram0_din,
               ram1_en, ram1_we, ram1_addr, ram1_din,
               ntt_start, busy, done, range_err
    );

    modport slave (
        input  load_req, s_valid, s_data, ntt_done,
        output s_ready, ram0_en, ram0_we, ram0_addr, ram0_din,
               ram1_en, ram1_we, ram1_addr, ram1_din,
               ntt_start, busy, done, range_err
    );
endinterface

// File: rtl/ntt_coef_loader.sv
// NTT input stage: reduces N streamed coefficients once mod Q, splits them into the
// x/y ping-pong banks, then starts the NTT and waits for its completion pulse.
//
// state | meaning
// IDLE  | waiting for load_req
// LOAD  | accepting coefficients, s_ready high
// DRAIN | last registered bank write retires
// START | ntt_start pulse
// WAIT  | waiting for ntt_done
module ntt_coef_loader #(
    parameter int DATA_W = 16,
    parameter int N      = 256,
    parameter int ADDR_W = 7,
    parameter int Q      = 3329
) (
    input  logic              clk,
    input  logic              rst_n,
    ntt_coef_loader_if.slave  bus
);
    localparam int CNT_W = $clog2(N);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    localparam logic [DATA_W:0]  Q_EXT     = (DATA_W+1)'(Q);
    localparam logic [DATA_W:0]  TWO_Q_EXT = (DATA_W+1)'(2*Q);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N-1);

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              done_q;
    logic              range_err_q;
    logic              hs;
    logic              hi_bank;
    logic [DATA_W:0]   data_ext;
    logic [DATA_W-1:0] data_red;

    assign bus.s_ready   = (state == S_LOAD);
    assign bus.ntt_start = (state == S_START);
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_q;
    assign bus.range_err = range_err_q;

    assign hs       = bus.s_valid & bus.s_ready;
    assign hi_bank  = cnt[CNT_W-1];
    assign data_ext = {1'b0, bus.s_data};
    // Extra bit keeps the compare/subtract wrap-free; the result always fits DATA_W.
    assign data_red = DATA_W'((data_ext >= Q_EXT) ? data_ext - Q_EXT : data_ext);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            done_q      <= 1'b0;
            range_err_q <= 1'b0;
            bus.ram0_en   <= 1'b0;
            bus.ram0_we   <= 1'b0;
            bus.ram0_addr <= '0;
            bus.ram0_din  <= '0;
            bus.ram1_en   <= 1'b0;
            bus.ram1_we   <= 1'b0;
            bus.ram1_addr <= '0;
            bus.ram1_din  <= '0;
        end else begin
            done_q      <= 1'b0;
            bus.ram0_en <= 1'b0;
            bus.ram0_we <= 1'b0;
            bus.ram1_en <= 1'b0;
            bus.ram1_we <= 1'b0;

            case (state)
                S_IDLE: begin
                    // done_q marks the cycle right after WAIT; a load_req there is too early.
                    if (bus.load_req && !done_q) begin
                        state       <= S_LOAD;
                        cnt         <= '0;
                        range_err_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (hs) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) state <= S_DRAIN;
                    end
                end
                S_DRAIN: state <= S_START;
                S_START: state <= S_WAIT;
                S_WAIT: begin
                    if (bus.ntt_done) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (hs) begin
                if (data_ext >= TWO_Q_EXT) range_err_q <= 1'b1;
                // Upper half feeds the y operand so stage 0 pairs k with k+N/2.
                if (hi_bank) begin
                    bus.ram1_en   <= 1'b1;
                    bus.ram1_we   <= 1'b1;
                    bus.ram1_addr <= cnt[ADDR_W-1:0];
                    bus.ram1_din  <= data_red;
                end else begin
                    bus.ram0_en   <= 1'b1;
                    bus.ram0_we   <= 1'b1;
                    bus.ram0_addr <= cnt[ADDR_W-1:0];
                    bus.ram0_din  <= data_red;
                end
            end
        end
    end
endmodule

// File: tb/tb_ntt_coef_loader.sv
// Self-checking bench for ntt_coef_loader: bank writes are checked against a queue of
// expected writes filled as coefficients are handed over.
module tb_ntt_coef_loader;
    localparam int DATA_W = 16;
    localparam int N      = 256;
    localparam int ADDR_W = 7;
    localparam int Q      = 3329;

    typedef struct packed {
        logic              bank;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
    } wr_t;

    logic clk;
    logic rst_n;
    ntt_coef_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ntt_coef_loader #(.DATA_W(DATA_W), .N(N), .ADDR_W(ADDR_W), .Q(Q)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_writes = 0;
    bit exp_rerr = 1'b0;
    wr_t exp_q[$];
    logic [DATA_W-1:0] coef [N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Write monitor: every bank write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        wr_t got;
        wr_t exp;
        if (rst_n && (bus.ram0_en || bus.ram1_en || bus.ram0_we || bus.ram1_we)) begin
            n_writes++;
            checks++;
            if ((bus.ram0_en && bus.ram1_en) || (bus.ram0_en !== bus.ram0_we) ||
                (bus.ram1_en !== bus.ram1_we)) begin
                errors++;
                $display("FAIL write_strobes: got en0=%b we0=%b en1=%b we1=%b, required one bank with en=we=1",
                         bus.ram0_en, bus.ram0_we, bus.ram1_en, bus.ram1_we);
            end
            got.bank = bus.ram1_en;
            got.addr = bus.ram1_en ? bus.ram1_addr : bus.ram0_addr;
            got.din  = bus.ram1_en ? bus.ram1_din  : bus.ram0_din;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got bank=%0d addr=%0d din=%0d, required no write",
                         got.bank, got.addr, got.din);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL bank_write: got bank=%0d addr=%0d din=%0d, required bank=%0d addr=%0d din=%0d",
                             got.bank, got.addr, got.din, exp.bank, exp.addr, exp.din);
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] reduce_once(input logic [DATA_W-1:0] d);
        int v;
        v = int'(d);
        if (v >= Q) v = v - Q;
        return DATA_W'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        bus.load_req = 1'b1;
        step();
        bus.load_req = 1'b0;
        exp_rerr = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.s_ready !== 1'b1 || bus.range_err !== 1'b0) begin
            errors++;
            $display("FAIL start_load: got busy=%b s_ready=%b range_err=%b, required 1 1 0",
                     bus.busy, bus.s_ready, bus.range_err);
        end
    endtask

    task automatic send_coefs(input int first, input int last, input bit gaps);
        int k;
        int guard;
        bit v;
        wr_t e;
        k = first;
        guard = 0;
        while (k <= last) begin
            if (guard > 4000) begin
                checks++;
                errors++;
                $display("FAIL load_timeout: stuck at coefficient %0d, required all up to %0d accepted", k, last);
                break;
            end
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_valid = v;
            bus.s_data  = coef[k];
            if (v && bus.s_ready) begin
                e.bank = (k >= N/2);
                e.addr = ADDR_W'(k % (N/2));
                e.din  = reduce_once(coef[k]);
                exp_q.push_back(e);
                if (int'(coef[k]) >= 2*Q) exp_rerr = 1'b1;
                k++;
            end
            step();
            guard++;
            checks++;
            if (bus.range_err !== exp_rerr) begin
                errors++;
                $display("FAIL range_err: got %b after coefficient %0d, required %b", bus.range_err, k-1, exp_rerr);
            end
        end
        bus.s_valid = 1'b0;
    endtask

    // Called right after the last handshake: DRAIN, then START, then WAIT.
    task automatic expect_start(input int writes_before);
        checks++;
        if (bus.s_ready !== 1'b0 || bus.ntt_start !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_cycle: got s_ready=%b ntt_start=%b busy=%b, required 0 0 1",
                     bus.s_ready, bus.ntt_start, bus.busy);
        end
        step();
        checks++;
        if (bus.ntt_start !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse: got ntt_start=%b two cycles after last handshake, required 1", bus.ntt_start);
        end
        step();
        checks++;
        if (bus.ntt_start !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL start_width: got ntt_start=%b busy=%b in WAIT, required 0 1", bus.ntt_start, bus.busy);
        end
        checks++;
        if ((n_writes - writes_before) != N || exp_q.size() != 0) begin
            errors++;
            $display("FAIL write_count: got %0d writes with %0d outstanding, required %0d and 0",
                     n_writes - writes_before, exp_q.size(), N);
        end
    endtask

    task automatic finish_ntt(input bit try_b2b);
        bus.ntt_done = 1'b1;
        step();
        bus.ntt_done = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done=%b busy=%b, required 1 0", bus.done, bus.busy);
        end
        if (try_b2b) bus.load_req = 1'b1;
        step();
        bus.load_req = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL after_done: got done=%b busy=%b s_ready=%b, required 0 0 0",
                     bus.done, bus.busy, bus.s_ready);
        end
    endtask

    task automatic full_load(input bit gaps);
        int w0;
        w0 = n_writes;
        start_load();
        send_coefs(0, N-1, gaps);
        expect_start(w0);
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        for (int k = 0; k < N; k++) coef[k] = DATA_W'(k);
        coef[0] = DATA_W'(2*Q);
        start_load();
        send_coefs(0, 9, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        outs = {bus.s_ready, bus.ram0_en, bus.ram0_we, bus.ram0_addr, bus.ram0_din,
                bus.ram1_en, bus.ram1_we, bus.ram1_addr, bus.ram1_din,
                bus.ntt_start, bus.busy, bus.done, bus.range_err};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h mid-load, required all zero", outs);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_pending: got %0d writes missing before reset, required 0", exp_q.size());
        end
        exp_q.delete();
        exp_rerr = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (bus.ntt_start !== 1'b0 || bus.busy !== 1'b0 || bus.range_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got ntt_start=%b busy=%b range_err=%b, required 0 0 0",
                     bus.ntt_start, bus.busy, bus.range_err);
        end
    endtask

    task automatic test_stream();
        for (int k = 0; k < N; k++) coef[k] = DATA_W'(k);
        full_load(1'b0);
        finish_ntt(1'b0);
    endtask

    task automatic test_reduction();
        for (int k = 0; k < N; k++) coef[k] = DATA_W'(k);
        coef[0] = DATA_W'(Q);
        coef[1] = DATA_W'(Q - 1);
        coef[2] = DATA_W'(2*Q - 1);
        coef[3] = DATA_W'(2*Q);
        coef[N/2] = DATA_W'(Q + 7);
        coef[N-1] = DATA_W'(2*Q - 1);
        full_load(1'b0);
        checks++;
        if (bus.range_err !== 1'b1) begin
            errors++;
            $display("FAIL range_err_sticky: got %b in WAIT, required 1", bus.range_err);
        end
        finish_ntt(1'b0);
    endtask

    task automatic test_gaps();
        for (int k = 0; k < N; k++) coef[k] = DATA_W'(k);
        full_load(1'b1);
        finish_ntt(1'b0);
    endtask

    task automatic test_ignored();
        int w0;
        for (int k = 0; k < N; k++) coef[k] = DATA_W'($urandom_range(0, 2*Q - 1));
        w0 = n_writes;
        start_load();
        send_coefs(0, 49, 1'b0);
        bus.load_req = 1'b1;
        bus.ntt_done = 1'b1;
        step();
        bus.load_req = 1'b0;
        bus.ntt_done = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL ignore_in_load: got done=%b busy=%b s_ready=%b, required 0 1 1",
                     bus.done, bus.busy, bus.s_ready);
        end
        send_coefs(50, N-1, 1'b0);
        expect_start(w0);
        bus.load_req = 1'b1;
        step();
        bus.load_req = 1'b0;
        step();
        checks++;
        if (bus.busy !== 1'b1 || bus.s_ready !== 1'b0 || bus.ntt_start !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_in_wait: got busy=%b s_ready=%b ntt_start=%b done=%b, required 1 0 0 0",
                     bus.busy, bus.s_ready, bus.ntt_start, bus.done);
        end
        finish_ntt(1'b0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < N; k++) coef[k] = DATA_W'(N - 1 - k);
        full_load(1'b0);
        finish_ntt(1'b1);
        step();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ignored: got busy=%b after load_req with done, required 0", bus.busy);
        end
        for (int k = 0; k < N; k++) coef[k] = DATA_W'($urandom_range(0, 2*Q - 1));
        full_load(1'b1);
        finish_ntt(1'b0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.load_req = 1'b0;
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.ntt_done = 1'b0;
        step();
        step();
        checks++;
        if (bus.s_ready !== 1'b0 || bus.busy !== 1'b0 || bus.ntt_start !== 1'b0 ||
            bus.ram0_en !== 1'b0 || bus.ram1_en !== 1'b0 || bus.done !== 1'b0 || bus.range_err !== 1'b0) begin
            errors++;
            $display("FAIL power_on_reset: got s_ready=%b busy=%b ntt_start=%b en0=%b en1=%b done=%b range_err=%b, required all 0",
                     bus.s_ready, bus.busy, bus.ntt_start, bus.ram0_en, bus.ram1_en, bus.done, bus.range_err);
        end
        rst_n = 1'b1;
        step();

        test_reset();
        test_stream();
        test_reduction();
        test_gaps();
        test_ignored();
        test_back_to_back();

        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_writes: got %0d expected writes never seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
